// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// keypad_scan_ctrl : 4x4 keypad row scanner, press/release debounce, one strobe per press. Rev 1.0
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SETTLE_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] key_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       cols_m, cols_s;
   logic [1:0]       row_idx, row_idx_n;
   logic [1:0]       col_idx, col_idx_n;
   logic [3:0]       col_pat, col_pat_n;
   logic [3:0]       key_row_n, key_code_n;
   logic             key_valid_n, key_held_n;
   logic             advance_row;
   logic [3:0]       col_act;
   logic             pat_valid;
   logic [1:0]       col_enc;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'h0;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         4'b11_11: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         cols_m <= 4'hF;
         cols_s <= 4'hF;
      end else begin
         cols_m <= cols;
         cols_s <= cols_m;
      end
   end

   // Exactly one low column is a usable key; none or several reads as no key.
   assign col_act   = ~cols_s;
   assign pat_valid = (col_act != 4'd0) && ((col_act & (col_act - 4'd1)) == 4'd0);

   always_comb begin
      col_enc = 2'd0;
      case (col_act)
         4'b0010: col_enc = 2'd1;
         4'b0100: col_enc = 2'd2;
         4'b1000: col_enc = 2'd3;
         default: col_enc = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         cnt       <= '0;
         row_idx   <= 2'd0;
         col_idx   <= 2'd0;
         col_pat   <= 4'hF;
         key_row   <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         row_idx   <= row_idx_n;
         col_idx   <= col_idx_n;
         col_pat   <= col_pat_n;
         key_row   <= key_row_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      row_idx_n   = row_idx;
      col_idx_n   = col_idx;
      col_pat_n   = col_pat;
      key_row_n   = key_row;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
      advance_row = 1'b0;

      unique case (state)
         SCAN: begin
            if (cnt == SETTLE_LAST) begin
               cnt_n = '0;
               if (pat_valid) begin
                  col_pat_n = cols_s;
                  col_idx_n = col_enc;
                  state_n   = PRESS_DB;
               end else begin
                  advance_row = 1'b1;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         PRESS_DB: begin
            if (cols_s != col_pat) begin
               cnt_n       = '0;
               advance_row = 1'b1;
               state_n     = SCAN;
            end else if (cnt == DEB_LAST) begin
               cnt_n       = '0;
               key_code_n  = key_map(row_idx, col_idx);
               key_valid_n = 1'b1;
               key_held_n  = 1'b1;
               state_n     = HELD;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (cols_s == 4'hF) begin
               cnt_n   = '0;
               state_n = REL_DB;
            end
         end
         REL_DB: begin
            if (cols_s != 4'hF) begin
               cnt_n   = '0;
               state_n = HELD;
            end else if (cnt == DEB_LAST) begin
               cnt_n       = '0;
               key_held_n  = 1'b0;
               advance_row = 1'b1;
               state_n     = SCAN;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
      endcase

      if (advance_row) begin
         row_idx_n = row_idx + 2'd1;
         key_row_n = {key_row[2:0], key_row[3]};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl : directed bench with a behavioural 4x4 keypad matrix. Rev 1.0
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cols;
   logic [3:0] key_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [3:0] pressed [4];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] row;
      logic [1:0] col;
      logic [3:0] code;
   } vec_t;

   vec_t tbl [16];

   keypad_scan_ctrl #(
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_CYCLES(8),
      .CNT_W          (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cols     (cols),
      .key_row  (key_row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // A closed switch pulls its column low while its row is driven low.
   always_comb begin
      cols = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!key_row[r]) cols = cols & ~pressed[r];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_strobe(input int bound, output int cycles, output bit got);
      got = 1'b0;
      cycles = 0;
      while (!got && cycles < bound) begin
         @(negedge clk);
         cycles++;
         if (key_valid) got = 1'b1;
      end
   endtask

   task automatic wait_release(input int bound, output int cycles, output bit fell);
      fell = 1'b0;
      cycles = 0;
      while (!fell && cycles < bound) begin
         @(negedge clk);
         cycles++;
         if (!key_held) fell = 1'b1;
      end
   endtask

   task automatic run_cycles(input int n, input logic [3:0] row_ref,
                             output int strobes, output int held_low, output int row_moves);
      strobes = 0;
      held_low = 0;
      row_moves = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (key_valid) strobes++;
         if (!key_held) held_low++;
         if (key_row != row_ref) row_moves++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int         cyc;
      bit         got;
      bit         fell;
      int         strobes, held_low, row_moves, bstrobes, bheld_low, t;
      logic [3:0] er;
      int         bound_cnt;

      tbl[0]  = '{2'd0, 2'd0, 4'h1};  tbl[1]  = '{2'd0, 2'd1, 4'h2};
      tbl[2]  = '{2'd0, 2'd2, 4'h3};  tbl[3]  = '{2'd0, 2'd3, 4'hA};
      tbl[4]  = '{2'd1, 2'd0, 4'h4};  tbl[5]  = '{2'd1, 2'd1, 4'h5};
      tbl[6]  = '{2'd1, 2'd2, 4'h6};  tbl[7]  = '{2'd1, 2'd3, 4'hB};
      tbl[8]  = '{2'd2, 2'd0, 4'h7};  tbl[9]  = '{2'd2, 2'd1, 4'h8};
      tbl[10] = '{2'd2, 2'd2, 4'h9};  tbl[11] = '{2'd2, 2'd3, 4'hC};
      tbl[12] = '{2'd3, 2'd0, 4'hE};  tbl[13] = '{2'd3, 2'd1, 4'h0};
      tbl[14] = '{2'd3, 2'd2, 4'hF};  tbl[15] = '{2'd3, 2'd3, 4'hD};

      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset key_row", key_row, 4'b1110);
      check("reset key_code", key_code, 4'h0);
      check("reset key_valid", key_valid, 1'b0);
      check("reset key_held", key_held, 1'b0);

      // Idle scan: each row dwells four cycles, wrapping after row 3.
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         er = ~(4'b0001 << ((k / 4) % 4));
         check($sformatf("idle row k=%0d", k), key_row, er);
         check($sformatf("idle valid k=%0d", k), key_valid, 1'b0);
         check($sformatf("idle code k=%0d", k), key_code, 4'h0);
      end

      for (int i = 0; i < 16; i++) begin
         pressed[tbl[i].row] = 4'b0001 << tbl[i].col;
         wait_strobe(60, cyc, got);
         er = ~(4'b0001 << tbl[i].row);
         check($sformatf("tbl%0d strobe", i), got, 1'b1);
         check($sformatf("tbl%0d code", i), key_code, tbl[i].code);
         check($sformatf("tbl%0d row", i), key_row, er);
         check($sformatf("tbl%0d held", i), key_held, 1'b1);
         run_cycles(20, er, strobes, held_low, row_moves);
         check($sformatf("tbl%0d extra strobes", i), strobes, 0);
         check($sformatf("tbl%0d held drops", i), held_low, 0);
         check($sformatf("tbl%0d row moves", i), row_moves, 0);
         pressed[tbl[i].row] = 4'h0;
         wait_release(40, cyc, fell);
         check($sformatf("tbl%0d release", i), fell, 1'b1);
         check($sformatf("tbl%0d code kept", i), key_code, tbl[i].code);
      end

      // Steady "6": latency from the first row-1 drive.
      bound_cnt = 0;
      while (key_row != 4'b1110 && bound_cnt < 40) begin @(negedge clk); bound_cnt++; end
      check("six wait row0", key_row, 4'b1110);
      pressed[1] = 4'b0100;
      bound_cnt = 0;
      while (key_row != 4'b1101 && bound_cnt < 40) begin @(negedge clk); bound_cnt++; end
      check("six wait row1", key_row, 4'b1101);
      wait_strobe(40, cyc, got);
      check("six strobe", got, 1'b1);
      check("six latency<=12", (cyc <= 12), 1'b1);
      check("six code", key_code, 4'h6);
      run_cycles(30, 4'b1101, strobes, held_low, row_moves);
      check("six hold strobes", strobes, 0);
      check("six hold held", held_low, 0);
      check("six hold row", row_moves, 0);

      // Release with 5 cycles of bounce, then a clean release.
      bstrobes = 0;
      bheld_low = 0;
      for (int i = 0; i < 5; i++) begin
         pressed[1] = (i % 2 == 1) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (key_valid) bstrobes++;
         if (!key_held) bheld_low++;
      end
      check("relbounce strobes", bstrobes, 0);
      check("relbounce held", bheld_low, 0);
      t = 1;
      while (key_held && t < 40) begin @(negedge clk); t++; end
      check("relbounce fell", key_held, 1'b0);
      check("relbounce fall time in 10..12", (t >= 10 && t <= 12), 1'b1);
      pressed[1] = 4'b0100;
      wait_strobe(60, cyc, got);
      check("repress strobe", got, 1'b1);
      check("repress code", key_code, 4'h6);
      pressed[1] = 4'h0;
      wait_release(40, cyc, fell);
      check("repress release", fell, 1'b1);

      // Two keys on row 3 ghost out; dropping one leaves a valid "0".
      pressed[3] = 4'b1010;
      run_cycles(48, key_row, strobes, held_low, row_moves);
      check("multikey strobes", strobes, 0);
      check("multikey held", key_held, 1'b0);
      pressed[3] = 4'b0010;
      wait_strobe(60, cyc, got);
      check("single c1 strobe", got, 1'b1);
      check("single c1 code", key_code, 4'h0);
      check("single c1 row", key_row, 4'b0111);
      pressed[3] = 4'h0;
      wait_release(40, cyc, fell);
      check("single c1 release", fell, 1'b1);

      // Press bounce on "6": toggle every 3 cycles, then steady.
      bstrobes = 0;
      for (int i = 0; i < 20; i++) begin
         pressed[1] = ((i / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (key_valid) bstrobes++;
      end
      check("pressbounce strobes", bstrobes, 0);
      pressed[1] = 4'b0100;
      run_cycles(60, 4'b1101, strobes, held_low, row_moves);
      check("pressbounce one strobe", strobes, 1);
      check("pressbounce code", key_code, 4'h6);
      check("pressbounce held", key_held, 1'b1);
      pressed[1] = 4'h0;
      wait_release(40, cyc, fell);
      check("pressbounce release", fell, 1'b1);

      // Reset while "F" is held; it must be reacquired as a fresh press.
      pressed[3] = 4'b0100;
      wait_strobe(60, cyc, got);
      check("F strobe", got, 1'b1);
      check("F code", key_code, 4'hF);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midheld reset held", key_held, 1'b0);
      check("midheld reset row", key_row, 4'b1110);
      check("midheld reset code", key_code, 4'h0);
      check("midheld reset valid", key_valid, 1'b0);
      wait_strobe(60, cyc, got);
      check("F reacquire strobe", got, 1'b1);
      check("F reacquire code", key_code, 4'hF);
      @(negedge clk);
      check("F reacquire strobe width", key_valid, 1'b0);
      pressed[3] = 4'h0;
      wait_release(40, cyc, fell);
      check("F release", fell, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
